// File: rtl/usb_rx_timer.sv
// ---------------------------------------------------------------------------
// usb_rx_timer
//
// Receive-side bit timer for the USB packet receiver. A phase counter is
// re-aligned by every line edge and produces one shift strobe per bit at the
// mid-bit sample point. Strobes are counted against the length of the
// currently selected field; a registered pulse marks field completion and,
// in the DATA field, every completed byte.
//
// Optional feature: define USB_RX_STUFF_CHECK_EN to enable bit-stuffing
// removal and violation detection. When undefined, every sample point strobes,
// d_orig_i is ignored and stuff_err_o is tied low.
//
// Parameters:
//   CLKS_PER_BIT    system clocks per USB bit period
//   SAMPLE_PHASE    0-based phase at which a bit is sampled (< CLKS_PER_BIT)
//
// Ports:
//   clk              system clock
//   n_rst            asynchronous active-low reset
//   d_edge_i         one-cycle pulse on any line transition
//   d_orig_i         decoded (post-NRZI) bit value
//   rcv_active_i     packet reception in progress
//   field_sel_i      current field: 0 SYNC, 1 PID, 2 CRC5, 3 CRC16, 4 DATA
//   shift_strobe_o   sample/shift d_orig this cycle (combinational)
//   bit_cnt_o        bits received in the current field
//   byte_received_o  pulse after every 8th bit of the DATA field
//   field_done_o     pulse when the field length is reached
//   stuff_err_o      pulse on a bit-stuffing violation
// ---------------------------------------------------------------------------
module usb_rx_timer #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_PHASE = 3
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_edge_i,
  input  logic       d_orig_i,
  input  logic       rcv_active_i,
  input  logic [2:0] field_sel_i,
  output logic       shift_strobe_o,
  output logic [6:0] bit_cnt_o,
  output logic       byte_received_o,
  output logic       field_done_o,
  output logic       stuff_err_o
);

  localparam int PHASE_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [PHASE_W-1:0] PHASE_MAX    = PHASE_W'(CLKS_PER_BIT - 1);
  localparam logic [PHASE_W-1:0] PHASE_SAMPLE = PHASE_W'(SAMPLE_PHASE);
  localparam logic [2:0]         FIELD_DATA   = 3'd4;

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [6:0]         bit_cnt_q, bit_cnt_d;
  logic [2:0]         field_q;
  logic               field_done_q, field_done_d;
  logic               byte_q, byte_d;
  logic               sample;
  logic               strobe;
  logic [6:0]         field_len;
  logic               field_valid;
  logic [6:0]         cnt_base;
  logic [6:0]         cnt_inc;

  // Phase counter: held at zero while idle, restarted by any line edge so the
  // sample point stays centred on the bit regardless of clock drift.
  always_comb begin
    phase_d = phase_q;
    if (!rcv_active_i || d_edge_i) begin
      phase_d = '0;
    end else if (phase_q == PHASE_MAX) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + PHASE_W'(1);
    end
  end

  assign sample = rcv_active_i && (phase_q == PHASE_SAMPLE);

`ifdef USB_RX_STUFF_CHECK_EN
  logic [2:0] ones_q, ones_d;
  logic       stuff_err_q, stuff_err_d;
  logic       stuff_bit;

  // After six consecutive ones the transmitter inserts a zero; that sample
  // is dropped instead of shifted, and a one there is a stuffing violation.
  // The run length deliberately survives field changes.
  assign stuff_bit = (ones_q == 3'd6);
  assign strobe    = sample && !stuff_bit;

  always_comb begin
    ones_d      = ones_q;
    stuff_err_d = 1'b0;
    if (!rcv_active_i) begin
      ones_d = '0;
    end else if (sample) begin
      if (stuff_bit) begin
        ones_d      = '0;
        stuff_err_d = d_orig_i;
      end else if (d_orig_i) begin
        ones_d = ones_q + 3'd1;
      end else begin
        ones_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ones_q      <= '0;
      stuff_err_q <= 1'b0;
    end else begin
      ones_q      <= ones_d;
      stuff_err_q <= stuff_err_d;
    end
  end

  assign stuff_err_o = stuff_err_q;
`else
  logic unused_d_orig;

  assign unused_d_orig = d_orig_i;
  assign strobe        = sample;
  assign stuff_err_o   = 1'b0;
`endif

  // Field length lookup; codes 5-7 are invalid and keep the counter idle.
  always_comb begin
    field_len   = 7'd0;
    field_valid = 1'b1;
    case (field_sel_i)
      3'd0:    field_len = 7'd8;
      3'd1:    field_len = 7'd8;
      3'd2:    field_len = 7'd5;
      3'd3:    field_len = 7'd16;
      3'd4:    field_len = 7'd64;
      default: field_valid = 1'b0;
    endcase
  end

  // Field bit counter. A field change restarts counting from zero, and a
  // strobe in that same cycle already belongs to the new field.
  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    field_done_d = 1'b0;
    byte_d       = 1'b0;
    cnt_base     = (field_sel_i != field_q) ? 7'd0 : bit_cnt_q;
    cnt_inc      = cnt_base + 7'd1;
    if (!rcv_active_i || !field_valid) begin
      bit_cnt_d = '0;
    end else if (strobe) begin
      if ((field_sel_i == FIELD_DATA) && (cnt_inc[2:0] == 3'b000)) begin
        byte_d = 1'b1;
      end
      if (cnt_inc == field_len) begin
        bit_cnt_d    = '0;
        field_done_d = 1'b1;
      end else begin
        bit_cnt_d = cnt_inc;
      end
    end else begin
      bit_cnt_d = cnt_base;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      phase_q      <= '0;
      bit_cnt_q    <= '0;
      field_q      <= '0;
      field_done_q <= 1'b0;
      byte_q       <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      bit_cnt_q    <= bit_cnt_d;
      field_q      <= field_sel_i;
      field_done_q <= field_done_d;
      byte_q       <= byte_d;
    end
  end

  assign shift_strobe_o  = strobe;
  assign bit_cnt_o       = bit_cnt_q;
  assign field_done_o    = field_done_q;
  assign byte_received_o = byte_q;

endmodule

// File: doc/usb_rx_timer.md
# usb_rx_timer

Receive-side bit timer for the USB encryptor's packet receiver. It recovers bit timing from the decoded line, producing one `shift_strobe` per received bit at the mid-bit sample point and re-aligning to every data edge. It counts strobes against the length of the current field and pulses `field_done` when the field is complete. It sits between the edge detector/NRZI decoder and the RX shift registers and RX control FSM.

## Interface
- `CLKS_PER_BIT`, default 8: system clocks per USB bit period.
- `SAMPLE_PHASE`, default 3: phase value, 0-based, at which a bit is sampled. Must be less than `CLKS_PER_BIT`.

Ports:
- `clk` input, 1 bit: system clock.
- `n_rst` input, 1 bit: reset, asynchronous, active-low.
- `d_edge` input, 1 bit: one-cycle pulse on any transition of the line.
- `d_orig` input, 1 bit: decoded (post-NRZI) bit value.
- `rcv_active` input, 1 bit: packet reception in progress.
- `field_sel` input, 3 bits: current field. 0 = SYNC (8 bits), 1 = PID (8), 2 = CRC5 (5), 3 = CRC16 (16), 4 = DATA (64). Values 5–7 are invalid.
- `shift_strobe` output, 1 bit: sample/shift `d_orig` this cycle.
- `bit_cnt` output, 7 bits: bits received in the current field.
- `byte_received` output, 1 bit: one-cycle pulse after every 8th bit of the DATA field.
- `field_done` output, 1 bit: one-cycle pulse when the field length is reached.
- `stuff_err` output, 1 bit: one-cycle pulse on a bit-stuffing violation.

## Operation
- **Phase counter** (range 0..CLKS_PER_BIT-1):
  - Held at 0 while `rcv_active`=0.
  - `d_edge`=1 loads 0 on the next cycle; this takes priority over incrementing.
  - Otherwise it increments and wraps from CLKS_PER_BIT-1 to 0.
- **Sample point:** a sample occurs when phase == SAMPLE_PHASE and `rcv_active`=1.
- **`shift_strobe`:** combinational. Equals the sample point, except that it is suppressed on a stuffed bit (see Configuration).
- **Field counter:** `bit_cnt` increments on `shift_strobe`.
  - On reaching the field length, `bit_cnt` returns to 0 and `field_done` pulses on the next cycle.
- **Field change:** a change of `field_sel` (compared against its registered copy) clears `bit_cnt`.
  - A `shift_strobe` in the same cycle counts toward the new field, so `bit_cnt` becomes 1.
- **Invalid `field_sel`** (5–7): strobes are still generated, `bit_cnt` holds at 0, and `field_done` never fires.
- **`byte_received`:** registered pulse, in DATA only, on the cycle after each strobe that makes `bit_cnt`[2:0] wrap to 0 (bits 8, 16, …, 64).
- **Receive end:** `rcv_active` falling clears the phase, `bit_cnt`, the ones counter, and any pending pulses, all on the next edge. Reception may end mid-field; no `field_done` is generated in that case.

## Timing
- All outputs reset to 0.
- First strobe after `d_edge` occurs SAMPLE_PHASE+1 cycles after the `d_edge` cycle (4 cycles by default).
- With no edges, subsequent strobes occur every CLKS_PER_BIT cycles.
- `field_done`, `byte_received`, and `stuff_err` are registered and appear 1 cycle after the causing sample.
- `bit_cnt` is updated 1 cycle after the strobe.
- `d_edge` on the same cycle as the sample point: the strobe still fires, and the phase then restarts at 0.
- Asynchronous reset mid-field returns every register to 0 immediately.

## Configuration
- `USB_RX_STUFF_CHECK_EN` defined:
  - A 3-bit ones counter counts consecutive sampled 1s and resets on a sampled 0.
  - When the counter is 6, the next sample is treated as a stuff bit:
    - no `shift_strobe`;
    - the counter clears;
    - if the sampled `d_orig`=1, `stuff_err` pulses.
  - The counter persists across field changes and is cleared by `rcv_active`=0.
- `USB_RX_STUFF_CHECK_EN` undefined: every sample point strobes, `d_orig` is unused, and `stuff_err` is tied to 0.

## Test plan
- **Edge alignment:** Reset, `rcv_active`=1, single `d_edge` at cycle T, no further edges. Required: `shift_strobe` at T+4, T+12, T+20.
- **Field completion:** `field_sel`=2 (CRC5) with 5 strobes. Required: `bit_cnt` 1..4, then 0 with `field_done` pulsing 1 cycle after the 5th strobe. `field_sel`=3 gives `field_done` after 16 strobes.
- **DATA field:** `field_sel`=4 with 64 strobes. Required: `byte_received` pulses 8 times, and `field_done` occurs once, coincident with the 8th `byte_received`.
- **Stuffing:** with `USB_RX_STUFF_CHECK_EN` defined, bits 1,1,1,1,1,1,0,1. Required: 7 strobes, the 0 is skipped, `stuff_err`=0. Repeating with 1 in the stuff position requires a `stuff_err` pulse.
- **Abort and field switch:**
  - `rcv_active` dropped at `bit_cnt`=3 of PID: required `bit_cnt`=0, no `field_done`, phase 0.
  - `field_sel` change coincident with a strobe: required `bit_cnt`=1.
